// File: rtl/expu_stream_ctrl.sv
// Round-robin front end that shares one expu_top pipeline between several
// valid/ready requesters and returns tagged results on one output channel.
module expu_stream_ctrl #(
    parameter int WIDTH = 16,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    localparam int TAG_W = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_op_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     expu_enable_o,
    output logic                     expu_clear_o,
    output logic [WIDTH-1:0]         expu_op_o,
    input  logic [WIDTH-1:0]         expu_res_i,
    output logic                     res_valid_o,
    output logic [WIDTH-1:0]         res_data_o,
    output logic [TAG_W-1:0]         res_tag_o,
    input  logic                     res_ready_i,
    output logic                     busy_o
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] v_q;
    logic [TAG_W-1:0]   t_q [LATENCY];
    logic [TAG_W-1:0]   rr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic             en;
    logic             issueAllowed;
    logic             grantValid;
    logic [TAG_W-1:0] grant;
    logic             acc;
    logic             outHs;
    logic [TAG_W-1:0] rr_d;

    // A result waiting at the tail freezes the whole pipeline, bubbles included.
    assign en           = ~v_q[LATENCY-1] | res_ready_i;
    assign issueAllowed = en & ~flush_i & ~rst_i;
    assign expu_enable_o = issueAllowed;
    assign expu_clear_o  = rst_i | flush_i;

    always_comb begin
        int idx;
        idx        = 0;
        grantValid = 1'b0;
        grant      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!grantValid && req_valid_i[idx]) begin
                grantValid = 1'b1;
                grant      = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = grantValid && (grant == TAG_W'(k)) && issueAllowed;
        end
    end

    assign expu_op_o = grantValid ? req_op_i[int'(grant)*WIDTH +: WIDTH] : '0;
    assign acc       = |(req_valid_i & req_ready_o);
    assign outHs     = v_q[LATENCY-1] & res_ready_i;
    assign rr_d      = (int'(grant) == NUM_REQ - 1) ? '0 : grant + TAG_W'(1);

    assign res_valid_o = v_q[LATENCY-1] & ~rst_i;
    assign res_tag_o   = t_q[LATENCY-1];
    assign res_data_o  = expu_res_i;
    assign busy_o      = (cnt_q != '0) & ~rst_i;

    // Flush empties the pipeline but keeps the fairness pointer where it was.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q   <= '0;
            rr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) t_q[i] <= '0;
        end else if (flush_i) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) t_q[i] <= '0;
        end else begin
            if (en) begin
                v_q[0] <= acc;
                t_q[0] <= grant;
                for (int i = 1; i < LATENCY; i++) begin
                    v_q[i] <= v_q[i-1];
                    t_q[i] <= t_q[i-1];
                end
            end
            if (acc) rr_q <= rr_d;
            case ({acc, outHs})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_expu_stream_ctrl.sv
// Directed bench for expu_stream_ctrl; expu_top is replaced by an
// enable-gated delay line so each result equals the operand that was issued.
module tb_expu_stream_ctrl;

    localparam int W   = 16;
    localparam int NR  = 4;
    localparam int LAT = 2;
    localparam int TW  = 2;

    logic            clkI = 1'b0;
    logic            rstI;
    logic            flushI;
    logic [NR-1:0]   reqValid;
    logic [NR*W-1:0] reqOp;
    logic [NR-1:0]   reqReady;
    logic            expuEnable;
    logic            expuClear;
    logic [W-1:0]    expuOp;
    logic [W-1:0]    expuRes;
    logic            resValid;
    logic [W-1:0]    resData;
    logic [TW-1:0]   resTag;
    logic            resReady;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int expG [9] = '{3, 3, 3, 3, 3, 1, 3, 1, 3};

    logic [W-1:0] pipe [LAT];

    expu_stream_ctrl #(.WIDTH(W), .NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk_i(clkI), .rst_i(rstI), .flush_i(flushI),
        .req_valid_i(reqValid), .req_op_i(reqOp), .req_ready_o(reqReady),
        .expu_enable_o(expuEnable), .expu_clear_o(expuClear),
        .expu_op_o(expuOp), .expu_res_i(expuRes),
        .res_valid_o(resValid), .res_data_o(resData), .res_tag_o(resTag),
        .res_ready_i(resReady), .busy_o(busy)
    );

    always #5 clkI = ~clkI;

    // Stand-in for expu_top: LAT-deep delay line, frozen by enable, zeroed by clear.
    always @(posedge clkI) begin
        if (expuClear) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (expuEnable) begin
            pipe[0] <= expuOp;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign expuRes = pipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid, input logic rdy,
                                 input logic fl, input logic rs);
        reqValid = valid;
        resReady = rdy;
        flushI   = fl;
        rstI     = rs;
    endtask

    task automatic setOp(input int k, input logic [W-1:0] val);
        reqOp[k*W +: W] = val;
    endtask

    task automatic tick();
        @(posedge clkI);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic resetPulse();
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("rst_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_clear", 32'(expuClear), 32'h1);
        checkOutput("rst_valid", 32'(resValid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reqOp = '0;
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
        tick();
        resetPulse();

        $display("[TB] single op");
        setOp(2, 16'h3F80);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("single_ready", 32'(reqReady), 32'h4);
        checkOutput("single_op", 32'(expuOp), 32'h3F80);
        checkOutput("single_busy0", 32'(busy), 32'h0);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("single_busy1", 32'(busy), 32'h1);
        checkOutput("single_valid1", 32'(resValid), 32'h0);
        tick();
        settle();
        checkOutput("single_valid2", 32'(resValid), 32'h1);
        checkOutput("single_data", 32'(resData), 32'h3F80);
        checkOutput("single_tag", 32'(resTag), 32'h2);
        checkOutput("single_busy2", 32'(busy), 32'h1);
        tick();
        settle();
        checkOutput("single_busy3", 32'(busy), 32'h0);
        checkOutput("single_valid3", 32'(resValid), 32'h0);
        tick();

        $display("[TB] round robin");
        resetPulse();
        for (int k = 0; k < NR; k++) setOp(k, 16'h1000 + 16'(k));
        for (int c = 0; c <= 10; c++) begin
            applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b1, 1'b0, 1'b0);
            settle();
            if (c < 8) checkOutput("rr_ready", 32'(reqReady), 32'h1 << (c % 4));
            if (c >= 2 && c < 10) begin
                checkOutput("rr_valid", 32'(resValid), 32'h1);
                checkOutput("rr_tag", 32'(resTag), 32'((c - 2) % 4));
                checkOutput("rr_data", 32'(resData), 32'h1000 + 32'((c - 2) % 4));
            end
            if (c == 10) checkOutput("rr_drain", 32'(resValid), 32'h0);
            tick();
        end

        $display("[TB] backpressure");
        setOp(0, 16'h2000);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("bp_ready0", 32'(reqReady), 32'h1);
        tick();
        setOp(0, 16'h2001);
        settle();
        tick();
        setOp(0, 16'h2002);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            settle();
            checkOutput("bp_hold_valid", 32'(resValid), 32'h1);
            checkOutput("bp_hold_tag", 32'(resTag), 32'h0);
            checkOutput("bp_hold_data", 32'(resData), 32'h2000);
            checkOutput("bp_enable", 32'(expuEnable), 32'h0);
            checkOutput("bp_ready", 32'(reqReady), 32'h0);
            checkOutput("bp_busy", 32'(busy), 32'h1);
            tick();
        end
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("bp_out0", 32'(resData), 32'h2000);
        checkOutput("bp_ready6", 32'(reqReady), 32'h1);
        tick();
        setOp(0, 16'h2003);
        settle();
        checkOutput("bp_out1", 32'(resData), 32'h2001);
        checkOutput("bp_out1_valid", 32'(resValid), 32'h1);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("bp_out2", 32'(resData), 32'h2002);
        tick();
        settle();
        checkOutput("bp_out3", 32'(resData), 32'h2003);
        checkOutput("bp_out3_valid", 32'(resValid), 32'h1);
        tick();
        settle();
        checkOutput("bp_empty", 32'(resValid), 32'h0);
        checkOutput("bp_idle", 32'(busy), 32'h0);
        tick();

        $display("[TB] flush");
        setOp(1, 16'h4001);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("fl_ready0", 32'(reqReady), 32'h2);
        tick();
        setOp(2, 16'h4002);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("fl_ready1", 32'(reqReady), 32'h4);
        tick();
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("fl_clear", 32'(expuClear), 32'h1);
        checkOutput("fl_noready", 32'(reqReady), 32'h0);
        checkOutput("fl_out", 32'(resData), 32'h4001);
        checkOutput("fl_out_valid", 32'(resValid), 32'h1);
        tick();
        setOp(0, 16'h4444);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("fl_after_valid", 32'(resValid), 32'h0);
        checkOutput("fl_after_busy", 32'(busy), 32'h0);
        checkOutput("fl_after_ready", 32'(reqReady), 32'h1);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("fl_new_pending", 32'(resValid), 32'h0);
        tick();
        settle();
        checkOutput("fl_new_valid", 32'(resValid), 32'h1);
        checkOutput("fl_new_tag", 32'(resTag), 32'h0);
        checkOutput("fl_new_data", 32'(resData), 32'h4444);
        tick();

        $display("[TB] mid-stream reset");
        setOp(1, 16'h5001);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("mr_ready0", 32'(reqReady), 32'h2);
        tick();
        setOp(2, 16'h5002);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("mr_stalled", 32'(resValid), 32'h1);
        tick();
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("mr_rst_valid", 32'(resValid), 32'h0);
        checkOutput("mr_rst_ready", 32'(reqReady), 32'h0);
        tick();
        for (int k = 0; k < NR; k++) setOp(k, 16'h6000 + 16'(k));
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("mr_valid", 32'(resValid), 32'h0);
        checkOutput("mr_busy", 32'(busy), 32'h0);
        checkOutput("mr_grant0", 32'(reqReady), 32'h1);
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("mr_no_ghost", 32'(resValid), 32'h0);
        tick();
        settle();
        checkOutput("mr_new_tag", 32'(resTag), 32'h0);
        checkOutput("mr_new_data", 32'(resData), 32'h6000);
        tick();

        $display("[TB] sparse requesters");
        setOp(1, 16'h7001);
        setOp(3, 16'h7003);
        for (int c = 0; c <= 10; c++) begin
            if (c < 5)      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
            else if (c < 9) applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0);
            else            applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
            settle();
            if (c < 9) checkOutput("sp_ready", 32'(reqReady), 32'h1 << expG[c]);
            if (c >= 2) begin
                checkOutput("sp_tag", 32'(resTag), 32'(expG[c-2]));
                checkOutput("sp_data", 32'(resData), 32'h7000 + 32'(expG[c-2]));
            end
            tick();
        end
        settle();
        checkOutput("sp_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
